dot_matrix_scanner: RTL

DOT_MATRIX_SCANNER -- requirements
Module: dot_matrix_scanner

---
 rtl/dot_matrix_scanner_if.sv | 20 ++
 rtl/dot_matrix_scanner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dot_matrix_scanner_if.sv
// Pixel-write and buffer-swap handshake between a display client and dot_matrix_scanner.
interface dot_matrix_scanner_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_op;
  logic [3:0] wr_row;
  logic [4:0] wr_col;
  logic       swap;
  logic       swap_done;

  modport master (
    output wr_valid, wr_op, wr_row, wr_col, swap,
    input  wr_ready, swap_done
  );

  modport slave (
    input  wr_valid, wr_op, wr_row, wr_col, swap,
    output wr_ready, swap_done
  );
endinterface

// File: rtl/dot_matrix_scanner.sv
// Row-scanned LED dot-matrix driver with framebuffer; outputs registered 1 cycle, wr_ready low only during clear-all.
// Optional second (front/back) framebuffer with swap when DOTM_DOUBLE_BUFFER_EN is defined.
module dot_matrix_scanner #(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int DWELL = 1,
  parameter int BLANK = 0
) (
  input  logic                reset,
  input  logic                div_clk_10k,
  input  logic                enable,
  dot_matrix_scanner_if.slave wr,
  output logic                frame_start,
  output logic [ROWS-1:0]     dotR,
  output logic [COLS-1:0]     dotC
);
  localparam int RW = $clog2(ROWS);
`ifdef DOTM_DOUBLE_BUFFER_EN
  localparam int AW = RW + 1;
`else
  localparam int AW = RW;
`endif
  localparam int NE = 1 << AW;
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
  localparam logic [7:0]      DW_LAST  = 8'(DWELL - 1);
  localparam logic [ROWS-1:0] ROW_MSB  = {1'b1, {(ROWS-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

  clr_state_t      state_q, state_d;
  logic [RW-1:0]   row_q, clr_row_q;
  logic [7:0]      dw_q;
  logic [COLS-1:0] fb [NE];
  logic [AW-1:0]   rd_idx, wr_idx, clr_idx;
  logic            ready, wr_acc, clr_acc, in_range, blank;
  logic [COLS-1:0] wr_mask;

  always_comb begin
    state_d = state_q;
    ready   = (state_q == ST_IDLE);
    wr_acc  = wr.wr_valid && ready;
    clr_acc = wr_acc && (wr.wr_op == 2'b11);
    case (state_q)
      ST_IDLE:  if (clr_acc) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_row_q == ROW_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    wr.wr_ready = ready;
  end

  assign in_range = ({1'b0, wr.wr_row} < 5'(ROWS)) && ({1'b0, wr.wr_col} < 6'(COLS));
  assign wr_mask  = COLS'(1) << wr.wr_col;

  // Clear-all wipes one row per cycle and owns the write port until done.
  always_ff @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      clr_row_q <= '0;
      for (int i = 0; i < NE; i++) fb[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        fb[clr_idx] <= '0;
        clr_row_q   <= clr_row_q + RW'(1);
      end else if (clr_acc) begin
        clr_row_q <= '0;
      end else if (wr_acc && in_range) begin
        case (wr.wr_op)
          2'b00:   fb[wr_idx] <= fb[wr_idx] | wr_mask;
          2'b01:   fb[wr_idx] <= fb[wr_idx] & ~wr_mask;
          2'b10:   fb[wr_idx] <= fb[wr_idx] ^ wr_mask;
          default: ;
        endcase
      end
    end
  end

  if (BLANK == 0) begin : g_noblank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = dw_q < 8'(BLANK);
  end

  always_ff @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      row_q       <= '0;
      dw_q        <= '0;
      dotR        <= '1;
      dotC        <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      row_q       <= '0;
      dw_q        <= '0;
      dotR        <= '1;
      dotC        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (row_q == '0) && (dw_q == '0);
      dotR        <= blank ? '1 : ~(ROW_MSB >> row_q);
      dotC        <= blank ? '0 : fb[rd_idx];
      if (dw_q == DW_LAST) begin
        dw_q  <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        dw_q <= dw_q + 8'd1;
      end
    end
  end

`ifdef DOTM_DOUBLE_BUFFER_EN
  logic front_q, swap_pend_q, swap_done_q, swap_req, do_swap;

  // Exchange only at a frame boundary (or when idle) so a frame never tears.
  always_comb begin
    swap_req = swap_pend_q | wr.swap;
    do_swap  = swap_req && (state_q == ST_IDLE) && !clr_acc &&
               (!enable || ((row_q == ROW_LAST) && (dw_q == DW_LAST)));
  end

  always_ff @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      front_q     <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      front_q     <= front_q ^ do_swap;
      swap_pend_q <= swap_req & ~do_swap;
      swap_done_q <= do_swap;
    end
  end

  assign rd_idx       = {front_q, row_q};
  assign wr_idx       = {~front_q, wr.wr_row[RW-1:0]};
  assign clr_idx      = {~front_q, clr_row_q};
  assign wr.swap_done = swap_done_q;
`else
  logic unused_swap;
  assign unused_swap  = wr.swap;
  assign rd_idx       = row_q;
  assign wr_idx       = wr.wr_row[RW-1:0];
  assign clr_idx      = clr_row_q;
  assign wr.swap_done = 1'b0;
`endif
endmodule
